// File: rtl/card_pkg.sv
// Shared definitions for the card dealer: state encoding, default sizes and card index type.
package card_pkg;

   localparam int unsigned DEF_DECK_SIZE = 52;
   localparam int unsigned DEF_HAND_SIZE = 7;
   localparam int unsigned DEF_CARD_W    = 6;
   localparam int unsigned DEF_RND_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_DRAW = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef logic [DEF_CARD_W-1:0] card_t;

endpackage

// File: rtl/card_range_reduce.sv
// Maps a random word into [0, rem) and flags words above the largest unbiased multiple of rem.
module card_range_reduce #(
   parameter int unsigned RND_W     = 8,
   parameter int unsigned CARD_W    = 6,
   parameter bit          REJECT_EN = 1'b0
) (
   input  logic [RND_W-1:0]  i_rnd,
   input  logic [CARD_W:0]   i_rem,
   output logic [CARD_W-1:0] o_mod_c,
   output logic              o_reject_c
);

   localparam int unsigned WW = ((RND_W > CARD_W) ? RND_W : CARD_W) + 1;

   logic [WW-1:0] w_rnd;
   logic [WW-1:0] w_rem;
   logic [WW-1:0] w_span;
   logic [WW-1:0] w_mod;
   logic [WW-1:0] w_limit;

   assign w_rnd  = WW'(i_rnd);
   assign w_rem  = WW'(i_rem);
   assign w_span = WW'(1) << RND_W;

   // rem is never zero while drawing; the guard keeps the divider defined when idle
   assign w_mod   = (w_rem == '0) ? '0     : (w_rnd % w_rem);
   assign w_limit = (w_rem == '0) ? w_span : (w_span - (w_span % w_rem));

   assign o_mod_c    = CARD_W'(w_mod);
   assign o_reject_c = REJECT_EN && (w_rnd >= w_limit);

endmodule

// File: rtl/card_dealer.sv
// Deals HAND_SIZE distinct cards by a partial Fisher-Yates shuffle driven by an external PRNG.
// Define CARD_DEALER_REJECT_EN to reject biased random words (variable latency, unbiased draws).
module card_dealer
   import card_pkg::*;
#(
   parameter int unsigned DECK_SIZE = DEF_DECK_SIZE,
   parameter int unsigned HAND_SIZE = DEF_HAND_SIZE,
   parameter int unsigned CARD_W    = DEF_CARD_W,
   parameter int unsigned RND_W     = DEF_RND_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [RND_W-1:0]             rnd_in,
   output logic                         busy,
   output logic                         done,
   output logic                         hand_valid,
   output logic [HAND_SIZE*CARD_W-1:0]  hand
);

`ifdef CARD_DEALER_REJECT_EN
   localparam bit REJECT_EN = 1'b1;
`else
   localparam bit REJECT_EN = 1'b0;
`endif

   localparam int unsigned REM_W = CARD_W + 1;

   state_e                       r_state;
   state_e                       w_state_nxt;
   logic [CARD_W-1:0]            r_i;
   logic [CARD_W-1:0]            r_deck [DECK_SIZE];
   logic                         r_busy;
   logic                         r_done;
   logic                         r_hand_valid;
   logic [HAND_SIZE*CARD_W-1:0]  r_hand;

   logic [REM_W-1:0]             w_rem;
   logic [CARD_W-1:0]            w_mod;
   logic                         w_reject;
   logic [CARD_W-1:0]            w_j;
   logic [CARD_W-1:0]            w_deck_i;
   logic [CARD_W-1:0]            w_deck_j;
   logic                         w_draw;

   assign w_rem = REM_W'(DECK_SIZE) - REM_W'(r_i);
   assign w_j   = r_i + w_mod;

   card_range_reduce #(
      .RND_W     (RND_W),
      .CARD_W    (CARD_W),
      .REJECT_EN (REJECT_EN)
   ) u_range_reduce (
      .i_rnd      (rnd_in),
      .i_rem      (w_rem),
      .o_mod_c    (w_mod),
      .o_reject_c (w_reject)
   );

   // Read ports for the two deck slots being swapped
   always_comb begin
      w_deck_i = '0;
      w_deck_j = '0;
      for (int n = 0; n < int'(DECK_SIZE); n++) begin
         if (CARD_W'(n) == r_i) w_deck_i = r_deck[n];
         if (CARD_W'(n) == w_j) w_deck_j = r_deck[n];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_draw      = 1'b0;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_INIT;
         ST_INIT: w_state_nxt = ST_DRAW;
         ST_DRAW: begin
            if (!w_reject) begin
               w_draw = 1'b1;
               if (r_i == CARD_W'(HAND_SIZE - 1)) w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: draw index, deck, hand and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i          <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_hand_valid <= 1'b0;
         r_hand       <= '0;
         for (int n = 0; n < int'(DECK_SIZE); n++) r_deck[n] <= CARD_W'(n);
      end else begin
         r_busy <= (w_state_nxt == ST_INIT) || (w_state_nxt == ST_DRAW);
         r_done <= (r_state == ST_DONE);
         if (r_state == ST_IDLE && start) begin
            r_i          <= '0;
            r_hand_valid <= 1'b0;
         end
         if (r_state == ST_DONE) r_hand_valid <= 1'b1;
         if (r_state == ST_INIT) begin
            for (int n = 0; n < int'(DECK_SIZE); n++) r_deck[n] <= CARD_W'(n);
         end
         if (w_draw) begin
            r_i <= r_i + CARD_W'(1);
            for (int k = 0; k < int'(HAND_SIZE); k++) begin
               if (CARD_W'(k) == r_i) r_hand[k*CARD_W +: CARD_W] <= w_deck_j;
            end
            // j == i falls into the first branch and rewrites the slot with itself
            for (int n = 0; n < int'(DECK_SIZE); n++) begin
               if (CARD_W'(n) == r_i)      r_deck[n] <= w_deck_j;
               else if (CARD_W'(n) == w_j) r_deck[n] <= w_deck_i;
            end
         end
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign hand_valid = r_hand_valid;
   assign hand       = r_hand;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: directed deals on a 52-card instance, random permutation deals on a 7-card instance.
module tb_card_dealer;

   localparam int unsigned HS  = 7;
   localparam int unsigned CW  = 6;
   localparam int unsigned CW7 = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [7:0]        rnd;
   logic              busy, done, hand_valid;
   logic [HS*CW-1:0]  hand;

   logic              start7;
   logic [7:0]        rnd7;
   logic              busy7, done7, hand_valid7;
   logic [HS*CW7-1:0] hand7;
   logic [15:0]       lfsr = 16'hACE1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [HS*CW-1:0] q_hand [$];
   logic [6:0]       q_mask [$];

   always #5 clk = ~clk;

   card_dealer u_dut (
      .clk(clk), .rst(rst), .start(start), .rnd_in(rnd),
      .busy(busy), .done(done), .hand_valid(hand_valid), .hand(hand)
   );

   card_dealer #(.DECK_SIZE(7), .HAND_SIZE(7), .CARD_W(3), .RND_W(8)) u_dut7 (
      .clk(clk), .rst(rst), .start(start7), .rnd_in(rnd7),
      .busy(busy7), .done(done7), .hand_valid(hand_valid7), .hand(hand7)
   );

   always @(negedge clk) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign rnd7 = lfsr[7:0];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [HS*CW-1:0] pack_hand(input int base);
      logic [HS*CW-1:0] r;
      r = '0;
      for (int k = 0; k < int'(HS); k++) r[k*CW +: CW] = CW'(base + k);
      return r;
   endfunction

   // Monitor for the 52-card instance: every done pulse consumes one expected hand
   always @(negedge clk) begin
      if (!rst && done) begin
         if (q_hand.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pulse");
         end else begin
            logic [HS*CW-1:0] exp_h;
            exp_h = q_hand.pop_front();
            check("hand_at_done", 64'(hand), 64'(exp_h));
            check("hand_valid_at_done", 64'(hand_valid), 64'd1);
         end
      end
   end

   // Monitor for the 7-card instance: each hand must cover every card exactly once
   always @(negedge clk) begin
      if (!rst && done7) begin
         logic [6:0] mask;
         logic [6:0] exp_m;
         mask = '0;
         for (int k = 0; k < int'(HS); k++) begin
            logic [CW7-1:0] c;
            c = hand7[k*CW7 +: CW7];
            if (c < 3'd7) mask[c] = 1'b1;
         end
         if (q_mask.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done7: got done=1 expected no pulse");
         end else begin
            exp_m = q_mask.pop_front();
            check("perm7_mask", 64'(mask), 64'(exp_m));
         end
      end
   end

   task automatic wait_done(input int max_cyc, output int lat);
      lat = -1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   // Issue one deal on the 52-card instance with constant rnd and check its latency
   task automatic deal(input logic [7:0] r, input int base, input string name);
      int lat;
      rnd = r;
      @(negedge clk);
      start = 1'b1;
      q_hand.push_back(pack_hand(base));
      @(posedge clk);
      #1;
      start = 1'b0;
      check({name, "_busy"}, 64'(busy), 64'd1);
      wait_done(40, lat);
      check({name, "_latency"}, 64'(lat), 64'(HS + 2));
   endtask

   initial begin
      int lat;
      int n_done;
      int edges [3];
      rst = 1'b1; start = 1'b0; start7 = 1'b0; rnd = '0;
      #3;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hand_valid", 64'(hand_valid), 64'd0);
      check("rst_hand", 64'(hand), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // rnd=0: every draw is a self-swap
      deal(8'd0, 0, "rnd0");
      repeat (3) @(negedge clk);
      check("hold_hand", 64'(hand), 64'(pack_hand(0)));
      check("hold_hand_valid", 64'(hand_valid), 64'd1);
      check("hold_busy", 64'(busy), 64'd0);

      // rnd=1: always swaps with the next card
      deal(8'd1, 1, "rnd1");

      // Reset three draws into a deal discards it
      rnd = 8'd0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("abort_hand_valid_cleared", 64'(hand_valid), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hand", 64'(hand), 64'd0);
      check("abort_hand_valid", 64'(hand_valid), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      deal(8'd0, 0, "after_abort");

      // start held high for 30 edges: three back-to-back deals
      @(negedge clk);
      rnd = 8'd0;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         q_hand.push_back(pack_hand(0));
         edges[k] = (k + 1) * int'(HS + 3) - 1;
      end
      n_done = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (n_done < 3) check("b2b_done_edge", 64'(k), 64'(edges[n_done]));
            n_done++;
         end
      end
      start = 1'b0;
      check("b2b_done_count", 64'(n_done), 64'd3);
      repeat (15) @(negedge clk);

`ifdef CARD_DEALER_REJECT_EN
      // Three rejected words at the first draw stretch latency by three
      rnd = 8'd0;
      @(negedge clk);
      start = 1'b1;
      q_hand.push_back(pack_hand(0));
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rnd = 8'd250;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rnd = 8'd0;
      check("reject_busy", 64'(busy), 64'd1);
      wait_done(40, lat);
      check("reject_latency", 64'(lat + 4), 64'(HS + 5));
      repeat (3) @(negedge clk);
`endif

      // 7-card deck dealt in full: every hand a permutation
      for (int d = 0; d < 1000; d++) begin
         bit got;
         @(negedge clk);
         start7 = 1'b1;
         q_mask.push_back(7'h7F);
         @(posedge clk);
         #1;
         start7 = 1'b0;
         got = 1'b0;
         for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (done7) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL perm7_timeout: got no done in 100 cycles expected done for deal %0d", d);
            break;
         end
      end

      repeat (4) @(negedge clk);
      check("queue_drained", 64'(q_hand.size()), 64'd0);
      check("queue7_drained", 64'(q_mask.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
